// File: rtl/uart_receiver_if.sv
// Serial line and received-byte outputs of uart_receiver.
// The line driver uses the master modport; the receiver uses slave.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 frame_error;
    logic                 busy;

    modport master (output rx, input data, data_valid, frame_error, busy);
    modport slave  (input rx, output data, data_valid, frame_error, busy);
endinterface

// File: rtl/uart_receiver.sv
// Oversampling 8N1-style UART receiver with stop-bit check and one-cycle valid/error strobes.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each bit centre, decisions one cycle later.
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input logic            clk_1843200hz,
    input logic            reset,
    uart_receiver_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] START_CNT = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] START_CNT = CW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [CW-1:0] BIT_CNT  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_RECOVER,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_sync1, r_sync2;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [BW-1:0]        r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_dv, w_dv_nxt;
    logic                 r_fe, w_fe_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 w_rx_s;
    logic                 w_smp;

    always_ff @(posedge clk_1843200hz) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

`ifdef UART_RX_MAJORITY_EN
    // r_hist[0] is rx_s at the centre, r_hist[1] one cycle before it.
    logic [1:0] r_hist;

    always_ff @(posedge clk_1843200hz) begin
        if (reset) r_hist <= 2'b11;
        else       r_hist <= {r_hist[0], w_rx_s};
    end

    assign w_smp = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
    assign w_smp = w_rx_s;
`endif

    always_ff @(posedge clk_1843200hz) begin
        if (reset) begin
            r_state <= S_RECOVER;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_dv    <= 1'b0;
            r_fe    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_dv    <= w_dv_nxt;
            r_fe    <= w_fe_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_dv_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;
        w_busy_nxt  = r_busy;
        case (r_state)
            // Wait for a high line so a reset or error mid-frame never
            // mistakes a low data bit for a start bit.
            S_RECOVER: begin
                w_busy_nxt = 1'b0;
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (r_cnt == START_CNT) begin
                    w_cnt_nxt = '0;
                    if (w_smp) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = '0;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_CNT) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_smp, r_shift[DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == LAST_BIT) w_state_nxt = S_STOP;
                end
            end
            // Leaving at the stop-bit centre lets a back-to-back start edge land in IDLE.
            S_STOP: begin
                if (r_cnt == BIT_CNT) begin
                    w_cnt_nxt  = '0;
                    w_busy_nxt = 1'b0;
                    if (w_smp) begin
                        w_data_nxt  = r_shift;
                        w_dv_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_fe_nxt    = 1'b1;
                        w_state_nxt = S_RECOVER;
                    end
                end
            end
            default: w_state_nxt = S_RECOVER;
        endcase
    end

    assign bus.data        = r_data;
    assign bus.data_valid  = r_dv;
    assign bus.frame_error = r_fe;
    assign bus.busy        = r_busy;
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the team's 8N1 transmitter.
- Oversamples the rx line, detects the start bit, and recovers 8 data bits, LSB first.
- Checks the stop bit.
- Delivers each byte with a one-cycle valid strobe to the downstream decoder module.

Parameters:
- OVERSAMPLE, 16: clock cycles per bit. Must be even and >= 8. Default matches 115200 baud at 1.8432 MHz.
- DATA_BITS, 8: data bits per frame, received LSB first.

Ports:
- clk_1843200hz  input  1  oversampling clock (OVERSAMPLE x baud rate).
- reset  input  1  reset, synchronous, active-high.
- rx  input  1  asynchronous serial line; idles high.
- data  output  DATA_BITS  last correctly framed byte. data[0] is the first serial data bit.
- data_valid  output  1  one-cycle pulse: data was updated with a new byte.
- frame_error  output  1  one-cycle pulse: stop bit was sampled low.
- busy  output  1  high from start-edge detection until the frame completes or is aborted.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; it has priority over all other logic.
- Reset values:
  - data=0, data_valid=0, frame_error=0, busy=0.
  - Both synchronizer flops=1.
  - Bit counter=0, sample counter=0.
  - State=RECOVER.
- Synchronizer: rx passes through a 2-flop synchronizer. The second-stage output is rx_s; all logic uses rx_s only.
- States: RECOVER, IDLE, START, DATA, STOP.
- RECOVER:
  - Go to IDLE on the first cycle rx_s==1; otherwise stay.
  - Purpose: a reset or error in mid-frame never re-triggers on a low data bit.
- IDLE:
  - When rx_s==0: go to START, clear sample counter, set busy=1. Call this edge t0.
- START:
  - Sample counter increments every cycle.
  - At count OVERSAMPLE/2-1 (cycle t0+OVERSAMPLE/2 for default timing), sample rx_s.
  - If 0: clear the counter and go to DATA.
  - If 1 (glitch or false start): return to IDLE, busy=0, no pulses.
- DATA:
  - Sample each bit when the counter reaches OVERSAMPLE-1, then clear the counter.
  - Bit i is sampled at t0+OVERSAMPLE/2+(i+1)*OVERSAMPLE and shifted into a holding register, LSB first.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - Sample at t0+OVERSAMPLE/2+(DATA_BITS+1)*OVERSAMPLE (cycle 152 after t0 by default).
  - If 1: on the next edge, load data from the holding register, pulse data_valid for exactly 1 cycle, set busy=0, go to IDLE.
  - If 0: pulse frame_error for 1 cycle, leave data unchanged, set busy=0, go to RECOVER.
- Back-to-back frames: a start bit whose falling edge arrives immediately after the stop bit's centre is accepted with no lost frame. IDLE is entered mid-stop-bit.
- Pulse exclusivity: data_valid and frame_error are never high in the same cycle.
- Hold: data holds its value between valid pulses.
- Reset mid-frame: the partial byte is discarded and no pulse is generated. The receiver rearms only after rx_s is seen high.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every sampling point (start, each data bit, stop) takes rx_s at centre-1, centre and centre+1.
  - The bit value is the 2-of-3 majority.
  - Each decision, and therefore data_valid and frame_error, occurs one cycle later than listed above.
  - Start check: a start is rejected if the majority is 1.
- Undefined: single sample at centre, timing exactly as in Behaviour.

Test Plan:
- Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), 16 cycles per bit -> data=8'hA5 and a 1-cycle data_valid 153 cycles after rx_s falls. frame_error stays 0; busy high throughout.
- Back-to-back frames 0x00 then 0xFF, no idle gap -> two data_valid pulses ~160 cycles apart, with data=8'h00 then 8'hFF.
- rx low for 4 cycles, then high -> no data_valid, no frame_error; busy high for ~8 cycles then 0; a following 0x3C frame is received correctly.
- Frame 0x3C with stop bit driven low, line then idles high, then frame 0x81 -> frame_error pulses once, data keeps its prior value, then data_valid with data=8'h81.
- reset asserted at bit 4 of a frame with rx still toggling -> all outputs 0 next cycle; no pulse for the aborted frame; the next full frame 0x5A is received.
- With UART_RX_MAJORITY_EN: 0xA5 frame with a 1-cycle inverted glitch exactly at bit 2's centre -> data=8'hA5, data_valid at cycle 154. Without the macro the same stimulus yields 8'hA1.
